// File: rtl/prbs_dac_mapper_if.sv
// Signal bundle between the PRBS source / register block and the DAC mapper.
// bit_valid is a one-cycle qualifier for bit_in with no ready: every pulse is consumed on that clock.
interface prbs_dac_mapper_if #(
    parameter int DAC_W  = 14,
    parameter int FRAC_W = 8
);
    logic                    enable;
    logic                    bit_in;
    logic                    bit_valid;
    logic                    polarity_inv;
    logic [DAC_W-1:0]        level_high;
    logic [DAC_W-1:0]        level_low;
    logic [DAC_W+FRAC_W-1:0] edge_step;
    logic [DAC_W-1:0]        dac_data;
    logic                    edge_busy;
    logic [31:0]             edge_count;
    logic [1:0]              state_dbg;

    modport master (
        output enable, bit_in, bit_valid, polarity_inv, level_high, level_low, edge_step,
        input  dac_data, edge_busy, edge_count, state_dbg
    );

    modport slave (
        input  enable, bit_in, bit_valid, polarity_inv, level_high, level_low, edge_step,
        output dac_data, edge_busy, edge_count, state_dbg
    );
endinterface

// File: rtl/prbs_dac_mapper.sv
// Maps the raw PRBS bit stream to DAC codes with a programmable linear edge ramp.
// acc holds the DAC code with FRAC_W fractional bits; dac_data is its integer part.
module prbs_dac_mapper #(
    parameter int DAC_W  = 14,
    parameter int FRAC_W = 8
) (
    input  logic             dac_clk,
    input  logic             reset_n,
    prbs_dac_mapper_if.slave bus
);
    localparam int AW = DAC_W + FRAC_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_RAMP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic          cur_bit_q, cur_bit_d;
    logic          edge_busy_q, edge_busy_d;
    logic [31:0]   edge_count_q, edge_count_d;

    logic             eb;
    logic             bit_change;
    logic             cur_bit_next;
    logic [DAC_W-1:0] tgt;
    logic [AW-1:0]    tgt_f;
    logic [AW-1:0]    low_f;
    logic [AW:0]      sum_ext;
    logic [AW-1:0]    diff;
    logic [AW-1:0]    step_acc;
    logic             step_done;

    assign eb         = bus.bit_in ^ bus.polarity_inv;
    assign bit_change = bus.enable && bus.bit_valid && (state_q != ST_IDLE) && (eb != cur_bit_q);

    // The target follows the bit captured this cycle, so a mid-ramp retarget steers at once.
    assign cur_bit_next = bit_change ? eb : cur_bit_q;
    assign tgt          = cur_bit_next ? bus.level_high : bus.level_low;
    assign tgt_f        = {tgt, {FRAC_W{1'b0}}};
    assign low_f        = {bus.level_low, {FRAC_W{1'b0}}};

    // One ramp step toward tgt_f; step_done means the target is reached this cycle.
    always_comb begin
        sum_ext   = {1'b0, acc_q} + {1'b0, bus.edge_step};
        diff      = acc_q - tgt_f;
        step_acc  = acc_q;
        step_done = 1'b0;
        if ((bus.edge_step == '0) || (acc_q == tgt_f)) begin
            step_done = 1'b1;
        end else if (acc_q < tgt_f) begin
            step_done = (sum_ext >= {1'b0, tgt_f});
            step_acc  = acc_q + bus.edge_step;
        end else begin
            step_done = (diff <= bus.edge_step);
            step_acc  = acc_q - bus.edge_step;
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cur_bit_d    = cur_bit_q;
        edge_count_d = edge_count_q + 32'(bit_change);
        if (!bus.enable) begin
            state_d   = ST_IDLE;
            acc_d     = low_f;
            cur_bit_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_HOLD;
                    acc_d     = low_f;
                    cur_bit_d = 1'b0;
                end
                ST_HOLD: begin
                    cur_bit_d = cur_bit_next;
                    if (bit_change && !step_done) begin
                        state_d = ST_RAMP;
                        acc_d   = step_acc;
                    end else begin
                        acc_d = tgt_f;
                    end
                end
                ST_RAMP: begin
                    cur_bit_d = cur_bit_next;
                    if (step_done) begin
                        state_d = ST_HOLD;
                        acc_d   = tgt_f;
                    end else begin
                        acc_d = step_acc;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    acc_d     = low_f;
                    cur_bit_d = 1'b0;
                end
            endcase
        end
        edge_busy_d = (state_d == ST_RAMP);
    end

    always_ff @(posedge dac_clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            cur_bit_q    <= 1'b0;
            edge_busy_q  <= 1'b0;
            edge_count_q <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cur_bit_q    <= cur_bit_d;
            edge_busy_q  <= edge_busy_d;
            edge_count_q <= edge_count_d;
        end
    end

    assign bus.dac_data   = acc_q[AW-1:FRAC_W];
    assign bus.edge_busy  = edge_busy_q;
    assign bus.edge_count = edge_count_q;
    assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_prbs_dac_mapper.sv
// Directed bench for prbs_dac_mapper: instant edges, ramps, clamping, retarget, polarity, enable and reset.
module tb_prbs_dac_mapper;
    localparam int DAC_W  = 14;
    localparam int FRAC_W = 8;

    logic dac_clk;
    logic reset_n;
    int   total;
    int   bad;

    prbs_dac_mapper_if #(.DAC_W(DAC_W), .FRAC_W(FRAC_W)) bus ();

    prbs_dac_mapper #(.DAC_W(DAC_W), .FRAC_W(FRAC_W)) dut (
        .dac_clk (dac_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial dac_clk = 1'b0;
    always #5 dac_clk = ~dac_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // One clock edge; outputs are then read 1 ns after it.
    task automatic tick();
        @(posedge dac_clk);
        #1;
    endtask

    task automatic pulse(input logic b);
        bus.bit_in    = b;
        bus.bit_valid = 1'b1;
        tick();
        bus.bit_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input int data, input logic busy);
        check({tag, "_data"}, 32'(bus.dac_data), 32'(data));
        check({tag, "_busy"}, 32'(bus.edge_busy), 32'(busy));
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        reset_n          = 1'b0;
        bus.enable       = 1'b1;
        bus.bit_in       = 1'b1;
        bus.bit_valid    = 1'b1;
        bus.polarity_inv = 1'b0;
        bus.level_high   = 14'd12000;
        bus.level_low    = 14'd4000;
        bus.edge_step    = '0;
        #1;
        tick();
        tick();
        expect_out("reset", 0, 1'b0);
        check("reset_count", bus.edge_count, 32'd0);
        check("reset_state", 32'(bus.state_dbg), 32'd0);

        bus.bit_valid = 1'b0;
        reset_n       = 1'b1;
        tick();
        expect_out("idle_exit", 4000, 1'b0);
        check("hold_state", 32'(bus.state_dbg), 32'd1);
        tick();

        // Instant edges
        pulse(1'b1);
        expect_out("inst_r1", 12000, 1'b0);
        for (int i = 0; i < 3; i++) begin tick(); check("inst_busy_a", 32'(bus.edge_busy), 32'd0); end
        pulse(1'b0);
        expect_out("inst_f", 4000, 1'b0);
        for (int i = 0; i < 3; i++) begin tick(); check("inst_busy_b", 32'(bus.edge_busy), 32'd0); end
        pulse(1'b1);
        expect_out("inst_r2", 12000, 1'b0);
        check("inst_count", bus.edge_count, 32'd3);

        // Level change in HOLD takes effect with no ramp
        bus.level_high = 14'd13000;
        tick();
        expect_out("lvl_hold", 13000, 1'b0);
        bus.level_high = 14'd12000;
        tick();
        pulse(1'b0);
        check("back_low_a", 32'(bus.dac_data), 32'd4000);

        // Linear ramp
        bus.edge_step = 22'(2000 << 8);
        pulse(1'b1);
        expect_out("lin1", 6000, 1'b1);
        tick(); expect_out("lin2", 8000, 1'b1);
        tick(); expect_out("lin3", 10000, 1'b1);
        tick(); expect_out("lin4", 12000, 1'b0);
        check("lin_count", bus.edge_count, 32'd5);

        // Fractional clamp
        bus.edge_step = '0;
        pulse(1'b0);
        bus.edge_step = 22'(3000 << 8);
        pulse(1'b1);
        expect_out("clamp1", 7000, 1'b1);
        tick(); expect_out("clamp2", 10000, 1'b1);
        tick(); expect_out("clamp3", 12000, 1'b0);
        tick(); expect_out("clamp4", 12000, 1'b0);

        // Mid-ramp reversal
        bus.edge_step = '0;
        pulse(1'b0);
        bus.edge_step = 22'(1000 << 8);
        pulse(1'b1);
        expect_out("rev1", 5000, 1'b1);
        tick(); expect_out("rev2", 6000, 1'b1);
        tick(); expect_out("rev3", 7000, 1'b1);
        pulse(1'b0);
        expect_out("rev4", 6000, 1'b1);
        tick(); expect_out("rev5", 5000, 1'b1);
        tick(); expect_out("rev6", 4000, 1'b0);
        check("rev_count", bus.edge_count, 32'd10);
        pulse(1'b0);
        check("same_bit_count", bus.edge_count, 32'd10);

        // Polarity inversion
        bus.edge_step    = '0;
        bus.polarity_inv = 1'b1;
        pulse(1'b1);
        expect_out("pol1", 4000, 1'b0);
        check("pol1_count", bus.edge_count, 32'd10);
        pulse(1'b0);
        expect_out("pol0", 12000, 1'b0);
        pulse(1'b1);
        expect_out("pol1b", 4000, 1'b0);
        check("pol_count", bus.edge_count, 32'd12);
        bus.polarity_inv = 1'b0;

        // Enable dropped mid-ramp, then bit_valid while disabled
        bus.edge_step = 22'(1000 << 8);
        pulse(1'b1);
        expect_out("en_r1", 5000, 1'b1);
        tick(); expect_out("en_r2", 6000, 1'b1);
        bus.enable = 1'b0;
        tick();
        expect_out("en_off", 4000, 1'b0);
        check("en_off_state", 32'(bus.state_dbg), 32'd0);
        pulse(1'b1);
        check("dis_count", bus.edge_count, 32'd13);
        check("dis_data", 32'(bus.dac_data), 32'd4000);
        bus.enable = 1'b1;
        tick();
        expect_out("en_on", 4000, 1'b0);

        // edge_step cleared mid-ramp finishes the edge on the next cycle
        pulse(1'b1);
        expect_out("st0_r1", 5000, 1'b1);
        bus.edge_step = '0;
        tick();
        expect_out("st0_done", 12000, 1'b0);
        bus.edge_step = 22'(1000 << 8);
        pulse(1'b0);
        expect_out("st0_down", 11000, 1'b1);

        // Reset mid-ramp
        reset_n = 1'b0;
        tick();
        expect_out("rst_mid", 0, 1'b0);
        check("rst_mid_count", bus.edge_count, 32'd0);
        reset_n = 1'b1;
        tick();
        expect_out("rst_rel", 4000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/prbs_dac_mapper.md
# prbs_dac_mapper

Converts the 1-bit raw PRBS stream from the PRBS LFSR core into DAC sample codes. Sits directly downstream of the LFSR stage and directly upstream of the DAC data path. Maps each bit to a programmable high or low code. Shapes each transition with a programmable linear edge ramp, so the rise/fall time is set independently of the bit rate.

## Interface
- DAC_W, 14, DAC code width.
- FRAC_W, 8, fractional bits of the internal ramp accumulator.
- dac_clk  in  1  system clock (DAC sample clock).
- reset_n  in  1  reset, synchronous, active-low.
- enable  in  1  mapper run enable.
- bit_in  in  1  raw PRBS bit (LFSR core prbs_bit_out).
- bit_valid  in  1  one-cycle pulse marking a new bit_in value. Driven by lfsr_clk_enable delayed one dac_clk, so it aligns with the updated prbs_bit_out.
- polarity_inv  in  1  invert the bit before mapping.
- level_high  in  DAC_W  unsigned code for logic 1.
- level_low  in  DAC_W  unsigned code for logic 0.
- edge_step  in  DAC_W+FRAC_W  ramp slew, in 1/2^FRAC_W codes per clock. 0 means an instant edge.
- dac_data  out  DAC_W  registered DAC sample.
- edge_busy  out  1  high while a ramp is in progress.
- edge_count  out  32  count of bit transitions, wraps modulo 2^32.

## Operation
- Effective bit is eb = bit_in ^ polarity_inv, captured only on bit_valid into cur_bit.
- Target is tgt = cur_bit ? level_high : level_low. tgt_f = tgt << FRAC_W.
- Accumulator acc is DAC_W+FRAC_W bits, unsigned. dac_data = acc[DAC_W+FRAC_W-1:FRAC_W] (truncation, no rounding).
- The FSM has three states: IDLE, HOLD and RAMP.
  - IDLE: entered on reset or when enable=0. acc = level_low << FRAC_W and cur_bit = 0. Goes to HOLD when enable=1.
  - HOLD: acc = tgt_f every cycle, so level register changes take effect with no ramp. On bit_valid with eb != cur_bit:
    - if edge_step = 0, stay in HOLD; acc jumps to the new target;
    - otherwise go to RAMP and take the first step in that same cycle.
  - RAMP, while acc < tgt_f: if acc + edge_step >= tgt_f (computed with one extra bit, no overflow), load acc = tgt_f and go to HOLD. Otherwise acc += edge_step.
  - RAMP, while acc > tgt_f: if acc - tgt_f <= edge_step, load acc = tgt_f and go to HOLD. Otherwise acc -= edge_step.
  - RAMP, when acc == tgt_f: go to HOLD.
- Retarget mid-ramp: a new bit_valid with a changed eb updates cur_bit. The ramp continues from the current acc toward the new target; there is no jump.
- Ramp direction is decided by comparing acc with tgt_f. level_high < level_low is legal (inverted swing).
- If edge_step becomes 0 during RAMP, acc loads tgt_f on the next cycle and the FSM goes to HOLD.
- edge_count increments on every bit_valid with eb != cur_bit, including changes mid-ramp. It does not count while enable=0.
- enable falling in any state: next cycle is IDLE. The in-progress ramp is abandoned and edge_busy = 0.
- bit_valid while enable=0 is ignored.

## Timing
- Reset values, applied on the first dac_clk edge with reset_n=0: state IDLE, acc 0, dac_data 0, cur_bit 0, edge_busy 0, edge_count 0.
- Reset overrides enable and bit_valid in the same cycle. Reset mid-ramp aborts the ramp immediately.
- Latency: bit_valid at edge N with a changed eb gives the first changed dac_data at N+1.
  - Instant edge: dac_data = new target at N+1.
  - Ramp of distance D codes: the ramp takes ceil(D·2^FRAC_W / edge_step) cycles. dac_data equals the target at N + that count.
- edge_busy is registered and equals (state == RAMP). It rises at N+1 and falls on the cycle dac_data reaches the target.
- Throughput: one bit_valid per clock is accepted, with no back-pressure.

## Test plan
- Instant edges: level_high=12000, level_low=4000, edge_step=0, enable=1, bits 1,0,1 on bit_valid at N, N+4, N+8. Expect dac_data 12000 at N+1, 4000 at N+5, 12000 at N+9; edge_count=3; edge_busy never high.
- Linear ramp: edge_step=2000<<8, 0→1 at N. Expect dac_data 6000, 8000, 10000, 12000 at N+1..N+4; edge_busy high for N+1..N+3 and low at N+4.
- Fractional clamp: edge_step=3000<<8, 0→1. Expect 7000, 10000, 12000 (clamped) at N+1..N+3, with no overshoot.
- Mid-ramp reversal: edge_step=1000<<8, bit 1 at N, bit 0 at N+3. Expect 5000, 6000, 7000, then 6000, 5000, 4000; edge_count=2.
- Polarity and enable: polarity_inv=1 and bit_in=1 give 4000. enable=0 mid-ramp gives dac_data 4000 next cycle and edge_busy=0; bit_valid while disabled leaves edge_count unchanged.
- Reset mid-ramp: reset_n=0 during RAMP. All outputs are 0 next edge. After release with enable=1, dac_data = level_low.
